player_input_conditioner: RTL and testbench



---
 rtl/genius_pkg.sv | 18 +
 rtl/button_debouncer.sv | 46 ++++
 rtl/player_input_conditioner.sv | 107 ++++++++++
 tb/tb_player_input_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types for the Genius game: colour codes and the input-conditioner FSM states.
package genius_pkg;

  localparam int COLOR_CODEFY_W = 2;

  typedef enum logic [COLOR_CODEFY_W-1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } color_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } cond_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Single-button synchroniser followed by a stable-level debouncer; o_stable only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_sync;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // The counter measures how long the synchronised level has disagreed with r_stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_input_conditioner.sv
// Debounces the four colour buttons and arbitrates them into one colour code plus
// single-cycle press / multi-press strobes for the game FSM.
//
//   state | meaning
//   IDLE  | no debounced button high; waiting for the next press
//   HELD  | a press (or illegal multi-press) was taken; waiting for full release
module player_input_conditioner
  import genius_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BUTTONS-1:0]    btn_raw,
  output logic [COLOR_CODEFY_W-1:0] player_button,
  output logic                      press_valid,
  output logic                      multi_press_err,
  output logic                      busy
);

  logic [NUM_BUTTONS-1:0]    w_stable;
  logic [COLOR_CODEFY_W-1:0] w_index;
  logic                      w_any;
  logic                      w_multi;

  cond_state_e               r_state,  w_state_nxt;
  logic [COLOR_CODEFY_W-1:0] r_button, w_button_nxt;
  logic                      r_valid,  w_valid_nxt;
  logic                      r_err,    w_err_nxt;
  logic                      r_busy,   w_busy_nxt;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  assign w_any   = |w_stable;
  assign w_multi = $countones(w_stable) > 1;

  // Only meaningful when exactly one bit is set, which is the only case it is used.
  always_comb begin
    w_index = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (w_stable[i]) w_index = COLOR_CODEFY_W'(i);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_button_nxt = r_button;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_multi) begin
            w_err_nxt = 1'b1;
          end else begin
            w_valid_nxt  = 1'b1;
            w_button_nxt = w_index;
          end
          w_busy_nxt  = 1'b1;
          w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (!w_any) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_button <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_button <= w_button_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign player_button   = r_button;
  assign press_valid     = r_valid;
  assign multi_press_err = r_err;
  assign busy            = r_busy;

endmodule

// File: tb/tb_player_input_conditioner.sv
// Directed and random stimulus for player_input_conditioner, checked every cycle
// against a history-based reference model of the button behaviour.
module tb_player_input_conditioner;
  import genius_pkg::*;

  localparam int NB   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [1:0]    player_button;
  logic          press_valid;
  logic          multi_press_err;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Reference model state: raw history (newest first), debounced levels, game-side outputs.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_s;
  logic          m_held;
  logic [1:0]    m_code;
  logic          m_valid, m_err, m_busy;

  // Per-step observations used by directed scenarios.
  int   n_valid, n_err, valid_at;
  logic [1:0] codes[$];

  player_input_conditioner #(
    .NUM_BUTTONS     (NB),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_raw         (btn_raw),
    .player_button   (player_button),
    .press_valid     (press_valid),
    .multi_press_err (multi_press_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC + DEB; k++) hist.push_back('0);
    m_s = '0; m_held = 1'b0; m_code = 2'd0;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
  endtask

  // One clock edge: game-side decision uses levels as they were before the edge;
  // a level flips once the last DEB samples the debouncer saw all disagree with it.
  task automatic model_edge(input logic [NB-1:0] raw);
    logic [NB-1:0] s_old;
    logic          all_diff;
    s_old   = m_s;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!m_held) begin
      if (s_old != '0) begin
        if ($countones(s_old) == 1) begin
          m_valid = 1'b1;
          for (int b = 0; b < NB; b++) if (s_old[b]) m_code = 2'(b);
        end else begin
          m_err = 1'b1;
        end
        m_busy = 1'b1;
        m_held = 1'b1;
      end
    end else if (s_old == '0) begin
      m_busy = 1'b0;
      m_held = 1'b0;
    end
    hist.push_front(raw);
    void'(hist.pop_back());
    for (int b = 0; b < NB; b++) begin
      all_diff = 1'b1;
      for (int k = SYNC; k < SYNC + DEB; k++) if (hist[k][b] == m_s[b]) all_diff = 1'b0;
      if (all_diff) m_s[b] = ~m_s[b];
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (press_valid === m_valid) else begin
      errors++; $error("FAIL press_valid: observed=%b expected=%b t=%0t", press_valid, m_valid, $time);
    end
    checks++;
    assert (multi_press_err === m_err) else begin
      errors++; $error("FAIL multi_press_err: observed=%b expected=%b t=%0t", multi_press_err, m_err, $time);
    end
    checks++;
    assert (busy === m_busy) else begin
      errors++; $error("FAIL busy: observed=%b expected=%b t=%0t", busy, m_busy, $time);
    end
    checks++;
    assert (player_button === m_code) else begin
      errors++; $error("FAIL player_button: observed=%0d expected=%0d t=%0t", player_button, m_code, $time);
    end
    checks++;
    assert (!(press_valid && multi_press_err)) else begin
      errors++; $error("FAIL strobe_overlap: observed=%b%b expected=not both", press_valid, multi_press_err);
    end
  endtask

  // Drive raw for n edges, checking each cycle and recording strobes.
  task automatic run(input logic [NB-1:0] raw, input int n);
    for (int i = 0; i < n; i++) begin
      btn_raw = raw;
      @(posedge clk);
      #1;
      model_edge(raw);
      check_outputs();
      if (press_valid) begin
        n_valid++;
        codes.push_back(player_button);
        if (valid_at < 0) valid_at = i;
      end
      if (multi_press_err) n_err++;
    end
  endtask

  task automatic clear_obs();
    n_valid = 0; n_err = 0; valid_at = -1; codes.delete();
  endtask

  task automatic expect_int(input string tag, input int observed, input int expected);
    checks++;
    assert (observed == expected) else begin
      errors++; $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [NB-1:0] pat;
    model_reset();
    clear_obs();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Clean press of blue, latency and hold of code after release
    clear_obs();
    run(4'b0100, 10);
    expect_int("clean_valid_cycle", valid_at, 6);
    run(4'b0000, 12);
    expect_int("clean_valid_count", n_valid, 1);
    expect_int("clean_code_after", int'(player_button), int'(BLUE));
    expect_int("clean_busy_after", int'(busy), 0);

    // Glitch shorter than the debounce window
    clear_obs();
    run(4'b0001, 3);
    run(4'b0000, 12);
    expect_int("glitch_valid_count", n_valid, 0);
    expect_int("glitch_busy", int'(busy), 0);

    // Sequence red, green, blue, yellow
    clear_obs();
    for (int c = 0; c < 4; c++) begin
      run(NB'(1) << c, 8);
      run(4'b0000, 8);
    end
    run(4'b0000, 4);
    expect_int("seq_valid_count", n_valid, 4);
    for (int c = 0; c < 4 && c < codes.size(); c++) expect_int("seq_code", int'(codes[c]), c);

    // Simultaneous press, extra button added while held
    clear_obs();
    run(4'b0011, 8);
    run(4'b0111, 8);
    expect_int("multi_err_count", n_err, 1);
    expect_int("multi_valid_count", n_valid, 0);
    expect_int("multi_code_kept", int'(player_button), int'(YELLOW));
    run(4'b0000, 12);
    expect_int("multi_busy_after", int'(busy), 0);

    // Hold yellow, add green; then a fresh green press
    clear_obs();
    run(4'b1000, 8);
    run(4'b1010, 8);
    run(4'b0000, 12);
    expect_int("hold2_valid_count", n_valid, 1);
    expect_int("hold2_busy_after", int'(busy), 0);
    clear_obs();
    run(4'b0010, 8);
    run(4'b0000, 12);
    expect_int("green_after_code", int'(player_button), int'(GREEN));
    expect_int("green_after_count", n_valid, 1);

    // Reset asserted mid-press aborts it
    clear_obs();
    run(4'b0100, 10);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    btn_raw = '0;
    rst = 1'b0;
    clear_obs();
    run(4'b0000, 20);
    expect_int("post_reset_strobes", n_valid + n_err, 0);

    // Random runs of mostly single buttons with occasional multi-presses and glitches
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 4))
        0:       pat = '0;
        1:       pat = NB'($urandom_range(0, 15));
        default: pat = NB'(1) << $urandom_range(0, NB - 1);
      endcase
      run(pat, $urandom_range(1, 12));
    end
    run(4'b0000, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule
